// File: rtl/cia_tod_seq.sv
// cia_tod_seq: turns one host command into a complete, untorn 4-byte TOD
// access on the CIA register bus. Bytes go hours, minutes, seconds, 10ths
// (addresses B, A, 9, 8), so the CIA's own stop-on-hours/restart-on-10ths
// and freeze-on-hours/release-on-10ths latching keeps the clock coherent.
//
// Handshake: a command transfers on the clk edge where cmd_valid, cmd_ready
// and phi2_dn are all high; cmd_ready is high only while idle. The response
// is a single phi2-cycle pulse on rsp_valid, with rsp_err qualifying it and
// no back-pressure on the response side.
module cia_tod_seq #(
    parameter int GAP       = 0,    // idle phi2 cycles between accesses (0..7)
    parameter bit CHECK_BCD = 1'b1  // reject writes carrying malformed BCD
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        phi2_dn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_alarm,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        bus_rd,
    output logic        bus_we,
    output logic [3:0]  bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        w_alarm
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_GAPW = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Last value of the gap counter before moving to the next access.
    localparam logic [2:0] GAP_LAST = 3'(GAP - 1);

    state_t      state_q,     state_d;
    logic [1:0]  idx_q,       idx_d;       // byte index: 0=hr .. 3=10ths
    logic [2:0]  gap_q,       gap_d;
    logic        write_q,     write_d;
    logic        alarm_q,     alarm_d;
    logic [31:0] data_q,      data_d;
    logic        err_q,       err_d;
    logic [23:0] shadow_q,    shadow_d;    // hr/min/sec bytes of a read in flight
    logic [31:0] rsp_data_q,  rsp_data_d;

    // Malformed BCD in a {hr, min, sec, 10ths} word. hr bit 7 is AM/PM.
    function automatic logic bcd_bad(input logic [31:0] d);
        logic bad;
        bad = 1'b0;
        if (d[7:4] != 4'h0 || d[3:0] > 4'd9)      bad = 1'b1;
        if (d[15:12] > 4'd5 || d[11:8] > 4'd9)    bad = 1'b1;
        if (d[23:20] > 4'd5 || d[19:16] > 4'd9)   bad = 1'b1;
        if (d[30:29] != 2'b00 || d[27:24] > 4'd9) bad = 1'b1;
        if (d[28] && d[27:24] > 4'd2)             bad = 1'b1;
        return bad;
    endfunction

    // Next-state logic: command latch, access sequencing and read capture.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        write_d    = write_q;
        alarm_d    = alarm_q;
        data_d     = data_q;
        err_d      = err_q;
        shadow_d   = shadow_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    alarm_d = cmd_alarm;
                    data_d  = cmd_data;
                    idx_d   = 2'd0;
                    gap_d   = 3'd0;
                    if (cmd_alarm && !cmd_write) begin
                        // Alarm registers are write-only on the CIA.
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (CHECK_BCD && cmd_write && bcd_bad(cmd_data)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (!write_q) begin
                    case (idx_q)
                        2'd0:    shadow_d[23:16] = bus_rdata;
                        2'd1:    shadow_d[15:8]  = bus_rdata;
                        2'd2:    shadow_d[7:0]   = bus_rdata;
                        default: shadow_d        = shadow_q;
                    endcase
                end
                if (idx_q == 2'd3) begin
                    // rsp_data only changes once the whole read is in hand.
                    if (!write_q) rsp_data_d = {shadow_q, bus_rdata};
                    state_d = S_RESP;
                end else if (GAP == 0) begin
                    idx_d = idx_q + 2'd1;
                end else begin
                    gap_d   = 3'd0;
                    state_d = S_GAPW;
                end
            end
            S_GAPW: begin
                if (gap_q == GAP_LAST) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_ACC;
                end else begin
                    gap_d = gap_q + 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; everything advances only on the phi2 end strobe.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            gap_q      <= 3'd0;
            write_q    <= 1'b0;
            alarm_q    <= 1'b0;
            data_q     <= 32'h0;
            err_q      <= 1'b0;
            shadow_q   <= 24'h0;
            rsp_data_q <= 32'h0;
        end else if (phi2_dn) begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            write_q    <= write_d;
            alarm_q    <= alarm_d;
            data_q     <= data_d;
            err_q      <= err_d;
            shadow_q   <= shadow_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Outputs decode straight from registers, so address, data and strobe
    // all move together on the same clk edge.
    assign cmd_ready = (state_q == S_IDLE);
    assign bus_we    = (state_q == S_ACC) && write_q;
    assign bus_rd    = (state_q == S_ACC) && !write_q;
    assign bus_addr  = (state_q == S_ACC) ? (4'hB - {2'b00, idx_q}) : 4'h0;
    assign bus_wdata = (state_q == S_ACC) ? data_q[{~idx_q, 3'b000} +: 8] : 8'h00;
    assign w_alarm   = alarm_q && ((state_q == S_ACC) || (state_q == S_GAPW));
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = (state_q == S_RESP) && err_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: doc/cia_tod_seq.md
Name: cia_tod_seq

Overview:
- Sequences complete 4-byte TOD accesses (time or alarm) onto the CIA register bus so the clock is never left half-updated and a read is never torn.
- Writes are ordered hours, minutes, seconds, 10ths: hours stops the clock, 10ths restarts it.
- Reads are ordered hours, minutes, seconds, 10ths: hours freezes the readout latch, 10ths releases it.
- Sits between a host command port (test harness/MCU bridge) and the CIA register interface; all bus activity is paced by phi2_dn.

Parameters:
- GAP, 0: idle phi2 cycles inserted between consecutive bus accesses (0..7).
- CHECK_BCD, 1: when 1, write commands carrying invalid BCD fields are rejected with err.

Ports:
- clk  in  1  system clock.
- res_n  in  1  asynchronous active-low reset.
- phi2_dn  in  1  one-clk strobe marking the end of each phi2 cycle; all state advances only on it.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready & phi2_dn.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_alarm  in  1  1 = target the alarm registers (write only).
- cmd_data  in  32  {hr, min, sec, 10ths} bytes, packed MSB to LSB.
- rsp_valid  out  1  one-phi2-cycle completion pulse.
- rsp_data  out  32  read result, same packing as cmd_data.
- rsp_err  out  1  qualifies rsp_valid; command rejected.
- bus_rd  out  1  register read strobe.
- bus_we  out  1  register write strobe.
- bus_addr  out  4  register address 8..B.
- bus_wdata  out  8  write data.
- bus_rdata  in  8  read data, valid in the phi2 cycle that has bus_rd set.
- w_alarm  out  1  alarm-select, held for the whole command.

Behaviour:
- Reset (async, res_n low): state IDLE; cmd_ready=1; rsp_valid=0; rsp_err=0; rsp_data=0; bus_rd=0; bus_we=0; bus_addr=0; bus_wdata=0; w_alarm=0. Any command in progress is abandoned with no response.
- FSM: IDLE -> ACC(i) -> GAPW -> ACC(i+1) ... -> RESP -> IDLE. Index i=0..3 maps to bus_addr B, A, 9, 8. GAPW is skipped when GAP=0.
- IDLE:
  - cmd_ready=1.
  - On acceptance, latch cmd_write, cmd_alarm and cmd_data.
  - Set w_alarm=cmd_alarm.
  - If cmd_alarm=1 and cmd_write=0: go directly to RESP with err=1, no bus cycles.
  - If CHECK_BCD=1 and the write is invalid: go to RESP with err=1, no bus cycles. Invalid means any of:
    - 10ths low nibble > 9 or upper nibble nonzero;
    - sec/min high digit > 5 or low digit > 9;
    - hr bits[6:5] nonzero, hl > 9, or hh=1 with hl > 2.
  - Otherwise go to ACC(0).
- ACC(i):
  - Held for exactly one phi2 cycle: outputs update on phi2_dn entering the state, drop on phi2_dn leaving it.
  - bus_we=cmd_write and bus_rd=~cmd_write, never both.
  - bus_wdata = latched byte i (hr first).
  - On read, capture bus_rdata into rsp_data byte (3-i) at the phi2_dn that leaves the state.
- GAPW: all strobes 0; counts GAP phi2 cycles.
- RESP:
  - rsp_valid=1 for one phi2 cycle, with rsp_err as set above.
  - rsp_data is stable until the next read completes.
  - w_alarm returns to 0; next state IDLE.
- cmd_ready=0 in every state except IDLE. A command is never accepted in the RESP cycle, so back-to-back commands are separated by at least one IDLE cycle.
- Latency in phi2 cycles, acceptance to rsp_valid: 4 + 3*GAP + 1 for a normal access; 1 for a rejected one.
- cmd_* inputs are ignored outside acceptance; changing them mid-command has no effect.
- Strobes change only on phi2_dn edges. No glitches between accesses: addr and data settle in the same clk that the strobe rises.

Test Plan:
- Write time 0x92_59_59_09 (PM 12:59:59.9), GAP=0:
  - bus sees we at B/0x92, A/0x59, 9/0x59, 8/0x09 on consecutive phi2 cycles, w_alarm=0;
  - rsp_valid 5 phi2 cycles after acceptance, err=0.
- Read with bus_rdata model returning 0x01, 0x23, 0x45, 0x06 for B, A, 9, 8:
  - rd order B, A, 9, 8;
  - rsp_data=0x01234506, err=0.
- Alarm write 0x11_30_00_00 with GAP=2:
  - w_alarm=1 across all four we cycles;
  - two idle phi2 cycles between each access;
  - rsp_valid at cycle 11; w_alarm=0 after.
- Invalid commands:
  - write 0x13_00_00_00 (hh=1, hl=3) -> no bus strobes, rsp_valid with err=1 one phi2 cycle later;
  - alarm read -> no bus strobes, err=1.
- res_n asserted after the A access of a write:
  - all outputs zero immediately (asynchronous), no rsp_valid;
  - cmd_ready=1 on release; a new read then completes normally.
- Backpressure: cmd_valid held high continuously:
  - second command accepted only after rsp_valid plus one IDLE cycle;
  - cmd_data changed mid-command does not alter the bus_wdata sequence.
